// File: rtl/prefetch_fifo_rr_drain_pkg.sv
// Shared types and sizing helpers for the round-robin prefetch FIFO drain scheduler.
package prefetch_fifo_rr_drain_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_BURST = 1'b1
    } state_t;

    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        r = 0;
        for (int unsigned p = 1; p < v; p = p << 1) begin
            r++;
        end
        return r;
    endfunction

    // Beat counter holds 0..BURST_LEN-1 with one spare bit so it never wraps inside a burst.
    function automatic int unsigned beat_cnt_w(input int unsigned burst_len);
        return clog2(burst_len) + 1;
    endfunction

endpackage

// File: rtl/prefetch_fifo_rr_drain_pick.sv
// Rotate-priority encoder: first asserted request at or after ptr, wrapping modulo N_SRC.
module prefetch_rr_pick
    import prefetch_fifo_rr_drain_pkg::*;
#(
    parameter int unsigned N_SRC = 4,
    parameter int unsigned SRC_W = 2
) (
    input  logic [N_SRC-1:0] req,
    input  logic [SRC_W-1:0] ptr,
    output logic [SRC_W-1:0] gnt,
    output logic             any
);

    int unsigned idx;

    always_comb begin
        gnt = '0;
        any = 1'b0;
        idx = 0;
        for (int unsigned k = 0; k < N_SRC; k++) begin
            // Explicit wrap keeps non-power-of-2 source counts correct.
            idx = int'(ptr) + k;
            if (idx >= N_SRC) begin
                idx = idx - N_SRC;
            end
            if (!any && req[idx]) begin
                gnt = SRC_W'(idx);
                any = 1'b1;
            end
        end
    end

endmodule

// File: rtl/prefetch_fifo_rr_drain.sv
// Round-robin scheduler draining N FWFT FIFO read ports into one valid/ready stream in fixed bursts.
module prefetch_fifo_rr_drain
    import prefetch_fifo_rr_drain_pkg::*;
#(
    parameter int unsigned N_SRC     = 4,
    parameter int unsigned DATA_W    = 8,
    parameter int unsigned BURST_LEN = 16,
    parameter int unsigned SRC_W     = 2
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    en,
    input  logic [N_SRC-1:0]        fifo_rd_vld,
    input  logic [N_SRC*DATA_W-1:0] fifo_rd_data,
    output logic [N_SRC-1:0]        fifo_rd_en,
    output logic [DATA_W-1:0]       out_data,
    output logic                    out_vld,
    input  logic                    out_ready,
    output logic [SRC_W-1:0]        out_src,
    output logic                    out_last,
    output logic                    busy
);

    localparam int unsigned CNT_W = beat_cnt_w(BURST_LEN);

    state_t           state, state_nxt;
    logic [SRC_W-1:0] gnt, gnt_nxt;
    logic [SRC_W-1:0] rr_ptr, rr_ptr_nxt;
    logic [CNT_W-1:0] beat_cnt, beat_nxt;
    logic [SRC_W-1:0] pick_gnt;
    logic             pick_any;
    logic             last_beat;
    logic             xfer;

    prefetch_rr_pick #(
        .N_SRC (N_SRC),
        .SRC_W (SRC_W)
    ) u_pick (
        .req (fifo_rd_vld),
        .ptr (rr_ptr),
        .gnt (pick_gnt),
        .any (pick_any)
    );

    assign busy      = (state == ST_BURST);
    assign out_src   = gnt;
    assign out_vld   = busy & fifo_rd_vld[gnt];
    assign last_beat = (beat_cnt == CNT_W'(BURST_LEN - 1));
    assign out_last  = out_vld & last_beat;
    assign xfer      = out_vld & out_ready;

    always_comb begin
        out_data   = '0;
        fifo_rd_en = '0;
        if (busy) begin
            out_data = fifo_rd_data[gnt*DATA_W +: DATA_W];
        end
        if (xfer) begin
            fifo_rd_en[gnt] = 1'b1;
        end
    end

    always_comb begin
        state_nxt  = state;
        gnt_nxt    = gnt;
        rr_ptr_nxt = rr_ptr;
        beat_nxt   = beat_cnt;
        case (state)
            ST_IDLE: begin
                if (en && pick_any) begin
                    gnt_nxt   = pick_gnt;
                    beat_nxt  = '0;
                    state_nxt = ST_BURST;
                end
            end
            ST_BURST: begin
                if (xfer) begin
                    if (last_beat) begin
                        rr_ptr_nxt = (gnt == SRC_W'(N_SRC - 1)) ? '0 : gnt + SRC_W'(1);
                        state_nxt  = ST_IDLE;
                    end else begin
                        beat_nxt = beat_cnt + CNT_W'(1);
                    end
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            gnt      <= '0;
            rr_ptr   <= '0;
            beat_cnt <= '0;
        end else begin
            state    <= state_nxt;
            gnt      <= gnt_nxt;
            rr_ptr   <= rr_ptr_nxt;
            beat_cnt <= beat_nxt;
        end
    end

endmodule

// File: tb/tb_prefetch_fifo_rr_drain.sv
// Directed table-driven bench for prefetch_fifo_rr_drain with a per-source FIFO data model.
module tb_prefetch_fifo_rr_drain;

    localparam int unsigned N_SRC     = 4;
    localparam int unsigned DATA_W    = 8;
    localparam int unsigned BURST_LEN = 16;
    localparam int unsigned SRC_W     = 2;

    logic                    clk;
    logic                    rst_n;
    logic                    en;
    logic [N_SRC-1:0]        fifo_rd_vld;
    logic [N_SRC*DATA_W-1:0] fifo_rd_data;
    logic [N_SRC-1:0]        fifo_rd_en;
    logic [DATA_W-1:0]       out_data;
    logic                    out_vld;
    logic                    out_ready;
    logic [SRC_W-1:0]        out_src;
    logic                    out_last;
    logic                    busy;

    int checks;
    int errors;

    logic [7:0] seq [N_SRC];
    int         xfer_cnt [N_SRC];

    typedef struct {
        int         rep;
        logic       en;
        logic [3:0] vld;
        logic       rdy;
        logic       busy;
        logic       ovld;
        logic [1:0] src;
        logic       last;
        logic [3:0] rden;
    } vec_t;

    vec_t vecs[$];

    prefetch_fifo_rr_drain #(
        .N_SRC     (N_SRC),
        .DATA_W    (DATA_W),
        .BURST_LEN (BURST_LEN),
        .SRC_W     (SRC_W)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .en           (en),
        .fifo_rd_vld  (fifo_rd_vld),
        .fifo_rd_data (fifo_rd_data),
        .fifo_rd_en   (fifo_rd_en),
        .out_data     (out_data),
        .out_vld      (out_vld),
        .out_ready    (out_ready),
        .out_src      (out_src),
        .out_last     (out_last),
        .busy         (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // FIFO model: head of source i is {i, pop count}; pops advance it.
    initial begin
        for (int i = 0; i < N_SRC; i++) seq[i] = 8'd0;
    end

    always @(posedge clk) begin
        for (int i = 0; i < N_SRC; i++) begin
            if (fifo_rd_en[i] && fifo_rd_vld[i]) seq[i] <= seq[i] + 8'd1;
        end
    end

    always_comb begin
        fifo_rd_data = '0;
        for (int i = 0; i < N_SRC; i++) begin
            fifo_rd_data[i*DATA_W +: DATA_W] = 8'(i * 64) | {2'b00, seq[i][5:0]};
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    task automatic add(input int rep, input logic e, input logic [3:0] v, input logic r,
                       input logic b, input logic ov, input logic [1:0] s, input logic l,
                       input logic [3:0] rd);
        vec_t t;
        t.rep = rep; t.en = e; t.vld = v; t.rdy = r; t.busy = b;
        t.ovld = ov; t.src = s; t.last = l; t.rden = rd;
        vecs.push_back(t);
    endtask

    // Full 16-beat burst from source s followed by the IDLE bubble cycle.
    task automatic burst(input logic [1:0] s, input logic [3:0] v, input logic [3:0] bub_vld);
        logic [3:0] oh;
        oh = 4'b0001 << s;
        add(BURST_LEN - 1, 1'b1, v, 1'b1, 1'b1, 1'b1, s, 1'b0, oh);
        add(1, 1'b1, v, 1'b1, 1'b1, 1'b1, s, 1'b1, oh);
        add(1, 1'b1, bub_vld, 1'b1, 1'b0, 1'b0, s, 1'b0, 4'b0000);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_rd_en"}, 32'(fifo_rd_en), 32'h0);
        chk({tag, "_out_vld"}, 32'(out_vld), 32'h0);
        chk({tag, "_busy"}, 32'(busy), 32'h0);
        chk({tag, "_out_last"}, 32'(out_last), 32'h0);
        chk({tag, "_out_src"}, 32'(out_src), 32'h0);
        chk({tag, "_out_data"}, 32'(out_data), 32'h0);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        for (int i = 0; i < N_SRC; i++) xfer_cnt[i] = 0;

        // Grant order 0,1,2,3,0; then wrap search with only src 2 valid; then src 0 after rr_ptr=3.
        add(1, 1'b1, 4'hF, 1'b1, 1'b0, 1'b0, 2'd0, 1'b0, 4'h0);
        burst(2'd0, 4'hF, 4'hF);
        burst(2'd1, 4'hF, 4'hF);
        burst(2'd2, 4'hF, 4'hF);
        burst(2'd3, 4'hF, 4'hF);
        burst(2'd0, 4'hF, 4'h4);
        burst(2'd2, 4'h4, 4'h4);
        burst(2'd2, 4'h4, 4'h5);
        add(BURST_LEN - 1, 1'b1, 4'h5, 1'b1, 1'b1, 1'b1, 2'd0, 1'b0, 4'h1);
        add(1, 1'b1, 4'h5, 1'b1, 1'b1, 1'b1, 2'd0, 1'b1, 4'h1);
        add(3, 1'b0, 4'hF, 1'b1, 1'b0, 1'b0, 2'd0, 1'b0, 4'h0);
        add(1, 1'b1, 4'hF, 1'b1, 1'b0, 1'b0, 2'd0, 1'b0, 4'h0);
        // Src 1: backpressure 1,0,0,1 then vld drop for 10 cycles after beat 5.
        add(1, 1'b1, 4'hF, 1'b1, 1'b1, 1'b1, 2'd1, 1'b0, 4'h2);
        add(2, 1'b1, 4'hF, 1'b0, 1'b1, 1'b1, 2'd1, 1'b0, 4'h0);
        add(1, 1'b1, 4'hF, 1'b1, 1'b1, 1'b1, 2'd1, 1'b0, 4'h2);
        add(3, 1'b1, 4'hF, 1'b1, 1'b1, 1'b1, 2'd1, 1'b0, 4'h2);
        add(10, 1'b1, 4'hD, 1'b1, 1'b1, 1'b0, 2'd1, 1'b0, 4'h0);
        add(10, 1'b1, 4'hF, 1'b1, 1'b1, 1'b1, 2'd1, 1'b0, 4'h2);
        add(1, 1'b1, 4'hF, 1'b1, 1'b1, 1'b1, 2'd1, 1'b1, 4'h2);
        add(1, 1'b1, 4'hF, 1'b1, 1'b0, 1'b0, 2'd1, 1'b0, 4'h0);
        // Src 2: en dropped after beat 3; burst still completes, then stays IDLE.
        add(3, 1'b1, 4'hF, 1'b1, 1'b1, 1'b1, 2'd2, 1'b0, 4'h4);
        add(12, 1'b0, 4'hF, 1'b1, 1'b1, 1'b1, 2'd2, 1'b0, 4'h4);
        add(1, 1'b0, 4'hF, 1'b1, 1'b1, 1'b1, 2'd2, 1'b1, 4'h4);
        add(3, 1'b0, 4'hF, 1'b1, 1'b0, 1'b0, 2'd2, 1'b0, 4'h0);
        add(1, 1'b1, 4'hF, 1'b1, 1'b0, 1'b0, 2'd2, 1'b0, 4'h0);
        add(4, 1'b1, 4'hF, 1'b1, 1'b1, 1'b1, 2'd3, 1'b0, 4'h8);

        rst_n = 1'b0;
        en = 1'b0;
        fifo_rd_vld = 4'hF;
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_reset_outputs("reset");
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        foreach (vecs[k]) begin
            for (int r = 0; r < vecs[k].rep; r++) begin
                en = vecs[k].en;
                fifo_rd_vld = vecs[k].vld;
                out_ready = vecs[k].rdy;
                @(negedge clk);
                chk($sformatf("v%0d_busy", k), 32'(busy), 32'(vecs[k].busy));
                chk($sformatf("v%0d_out_vld", k), 32'(out_vld), 32'(vecs[k].ovld));
                chk($sformatf("v%0d_out_src", k), 32'(out_src), 32'(vecs[k].src));
                chk($sformatf("v%0d_out_last", k), 32'(out_last), 32'(vecs[k].last));
                chk($sformatf("v%0d_rd_en", k), 32'(fifo_rd_en), 32'(vecs[k].rden));
                if (vecs[k].ovld) begin
                    chk($sformatf("v%0d_out_data", k), 32'(out_data),
                        32'(8'(int'(vecs[k].src) * 64) | {2'b00, seq[vecs[k].src][5:0]}));
                    if (vecs[k].rdy) xfer_cnt[vecs[k].src]++;
                end
                @(posedge clk);
                #1;
            end
        end

        // Async reset pulse in the middle of src 3's burst.
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("async_rst");
        @(negedge clk);
        check_reset_outputs("rst_hold");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        en = 1'b1;
        fifo_rd_vld = 4'hF;
        out_ready = 1'b0;
        @(negedge clk);
        chk("post_rst_idle_busy", 32'(busy), 32'h0);
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("post_rst_busy", 32'(busy), 32'h1);
        chk("post_rst_src", 32'(out_src), 32'h0);
        chk("post_rst_vld", 32'(out_vld), 32'h1);
        chk("post_rst_rd_en", 32'(fifo_rd_en), 32'h0);
        chk("post_rst_data", 32'(out_data), 32'({2'b00, seq[0][5:0]}));

        for (int i = 0; i < N_SRC; i++) begin
            chk($sformatf("pops_vs_xfers_src%0d", i), 32'(seq[i]), 32'(xfer_cnt[i]));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        errors++;
        $display("FAIL timeout: simulation did not complete");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $fatal(1);
    end

endmodule
